// File: rtl/prog_loader_if.sv
// Bundle of stream, memory-write and status signals between the program loader and its environment.
// Stream handshake: a byte moves on a rising clock edge only when in_valid and in_ready are both 1;
// in_valid/in_byte may change freely while in_ready is 0, and in_ready never depends on in_valid.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset_n;
    logic        done;
    logic        err;
    logic [15:0] word_count;
    logic [2:0]  dbg_state;

    modport slave (
        input  in_valid, in_byte, restart,
        output in_ready, mem_we, mem_addr, mem_wdata, core_reset_n, done, err, word_count, dbg_state
    );

    modport master (
        output in_valid, in_byte, restart,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_reset_n, done, err, word_count, dbg_state
    );
endinterface

// File: rtl/prog_loader.sv
// Boot program loader: receives a length-prefixed, XOR-checksummed byte stream, writes 32-bit
// instruction words to memory, and releases the core from reset only after a verified load.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic          clock,
    input  logic          reset,
    prog_loader_if.slave  io_bus
);
    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word_buf;
    logic [7:0]  r_xor;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [15:0] r_word_count;

    logic        w_in_ready;
    logic        w_accept;
    logic [15:0] w_len;
    logic        w_len_ok;
    logic        w_word_end;
    logic        w_last_byte;
    logic        w_restart;

    assign w_in_ready  = (r_state != ST_DONE) && (r_state != ST_ERROR);
    assign w_accept    = io_bus.in_valid && w_in_ready;
    assign w_restart   = io_bus.restart && !w_in_ready;
    assign w_len       = {io_bus.in_byte, r_len_lo};
    assign w_len_ok    = (w_len != 16'd0) && ({16'd0, w_len} <= LP_MAX_WORDS);
    assign w_word_end  = (r_byte_cnt == 2'd3);
    // word_count still holds the index of the word being assembled, so +1 reaching L marks the last byte
    assign w_last_byte = w_word_end && ((r_word_count + 16'd1) == r_len);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_LEN0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LEN0:  if (w_accept) w_next_state = ST_LEN1;
            ST_LEN1:  if (w_accept) w_next_state = w_len_ok ? ST_DATA : ST_ERROR;
            ST_DATA:  if (w_accept && w_last_byte) w_next_state = ST_CSUM;
            ST_CSUM:  if (w_accept) w_next_state = (io_bus.in_byte == r_xor) ? ST_DONE : ST_ERROR;
            ST_DONE:  if (w_restart) w_next_state = ST_LEN0;
            ST_ERROR: if (w_restart) w_next_state = ST_LEN0;
            default:  w_next_state = ST_LEN0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_word_buf   <= 24'd0;
            r_xor        <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_word_count <= 16'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_LEN0: r_len_lo <= io_bus.in_byte;
                    ST_LEN1: r_len    <= w_len;
                    ST_DATA: begin
                        r_xor      <= r_xor ^ io_bus.in_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // newest byte enters at the top so byte0 ends up in [7:0]
                        r_word_buf <= {io_bus.in_byte, r_word_buf[23:8]};
                        if (w_word_end) begin
                            r_mem_we     <= 1'b1;
                            r_mem_wdata  <= {io_bus.in_byte, r_word_buf};
                            r_mem_addr   <= BASE_ADDR + {14'd0, r_word_count, 2'b00};
                            r_word_count <= r_word_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_restart) begin
                r_byte_cnt   <= 2'd0;
                r_word_buf   <= 24'd0;
                r_xor        <= 8'd0;
                r_word_count <= 16'd0;
            end
        end
    end

    assign io_bus.in_ready     = w_in_ready;
    assign io_bus.mem_we       = r_mem_we;
    assign io_bus.mem_addr     = r_mem_addr;
    assign io_bus.mem_wdata    = r_mem_wdata;
    assign io_bus.word_count   = r_word_count;
    assign io_bus.done         = (r_state == ST_DONE);
    assign io_bus.err          = (r_state == ST_ERROR);
    assign io_bus.core_reset_n = (r_state == ST_DONE);
    assign io_bus.dbg_state    = r_state;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: streams built from word lists, a write scoreboard fed by a
// stream-level model, and status checks after each load.
module tb_prog_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    prog_loader_if bus ();

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          first_acc = -1;
    int          last_acc = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // accepted-byte monitor: values seen at the edge are the pre-edge values
    always @(posedge clock) begin
        cyc++;
        if (!reset && bus.in_valid && bus.in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
        end
    end

    // write scoreboard; an unexpected write is compared against an unaligned sentinel that can never match
    always @(posedge clock) begin
        #1;
        if (bus.mem_we) begin
            logic [63:0] exp_wr;
            exp_wr = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
            check("mem_write", {bus.mem_addr, bus.mem_wdata}, exp_wr);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            bus.restart  = 1'b0;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clock);
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'($urandom);
                bus.restart  = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.restart  = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.restart  = 1'b1;
        @(negedge clock);
        bus.restart  = 1'b0;
        check("restart_word_count", 64'(bus.word_count), 64'd0);
        check("restart_in_ready", 64'(bus.in_ready), 64'd1);
        check("restart_done_err", {62'd0, bus.done, bus.err}, 64'd0);
    endtask

    // stream model: L, 4*L little-endian payload bytes, XOR of payload bytes
    task automatic run_load(input string tag, input logic [15:0] len, input bit bad_csum, input bit gaps);
        logic [7:0] x;
        logic [7:0] by;
        bit         len_ok;
        int         nbytes;
        x         = 8'd0;
        len_ok    = (len != 16'd0) && (int'(len) <= MAXW);
        nbytes    = len_ok ? (2 + 4 * int'(len) + 1) : 2;
        acc_cnt   = 0;
        first_acc = -1;
        drive_byte(len[7:0], gaps);
        drive_byte(len[15:8], gaps);
        if (len_ok) begin
            for (int k = 0; k < int'(len); k++) begin
                exp_q.push_back({BASE + 32'(4 * k), words[k]});
                for (int b = 0; b < 4; b++) begin
                    by = words[k][8*b +: 8];
                    x  = x ^ by;
                    drive_byte(by, gaps);
                end
            end
            drive_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
        end else begin
            for (int b = 0; b < 4; b++) drive_byte(8'($urandom), gaps);
        end
        idle(3);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_accepted"}, 64'(acc_cnt), 64'(nbytes));
        check({tag, "_done"}, 64'(bus.done), 64'(len_ok && !bad_csum));
        check({tag, "_err"}, 64'(bus.err), 64'(!(len_ok && !bad_csum)));
        check({tag, "_core_reset_n"}, 64'(bus.core_reset_n), 64'(len_ok && !bad_csum));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_word_count"}, 64'(bus.word_count), len_ok ? 64'(len) : 64'd0);
        if (len_ok && !gaps) check({tag, "_throughput"}, 64'(last_acc - first_acc + 1), 64'(nbytes));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'd0;
        bus.restart  = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_word_count", 64'(bus.word_count), 64'd0);
        check("rst_done_err", {62'd0, bus.done, bus.err}, 64'd0);
        check("rst_core_reset_n", 64'(bus.core_reset_n), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        // nominal two-word load; payload XOR of this stream is 8'hB0
        words = '{32'h00100513, 32'h00200593};
        run_load("nominal", 16'd2, 1'b0, 1'b0);

        do_restart();
        run_load("csum_err", 16'd2, 1'b1, 1'b0);
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0);
        idle(2);
        check("err_bytes_ignored", 64'(acc_cnt), 64'd0);
        check("err_word_count_held", 64'(bus.word_count), 64'd2);

        do_restart();
        run_load("len_zero", 16'd0, 1'b0, 1'b0);
        do_restart();
        run_load("len_over", 16'(MAXW + 1), 1'b0, 1'b0);
        do_restart();
        words.delete();
        for (int i = 0; i < MAXW; i++) words.push_back(32'($urandom));
        run_load("len_max", 16'(MAXW), 1'b0, 1'b0);

        do_restart();
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back(32'($urandom));
        run_load("stream_cont", 16'd3, 1'b0, 1'b0);
        do_restart();
        run_load("stream_gaps", 16'd3, 1'b0, 1'b1);

        // reset after byte 2 of word 1, with restart and a valid byte in the same cycle
        do_restart();
        words = '{32'h00100513, 32'h00200593};
        exp_q.push_back({BASE, words[0]});
        drive_byte(8'h02, 1'b0);
        drive_byte(8'h00, 1'b0);
        for (int b = 0; b < 4; b++) drive_byte(words[0][8*b +: 8], 1'b0);
        drive_byte(words[1][7:0], 1'b0);
        drive_byte(words[1][15:8], 1'b0);
        @(negedge clock);
        reset       = 1'b1;
        bus.restart = 1'b1;
        bus.in_byte = words[1][23:16];
        @(negedge clock);
        reset        = 1'b0;
        bus.restart  = 1'b0;
        bus.in_valid = 1'b0;
        idle(3);
        check("midrst_writes_left", 64'(exp_q.size()), 64'd0);
        check("midrst_word_count", 64'(bus.word_count), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
        run_load("after_rst", 16'd2, 1'b0, 1'b0);

        do_restart();
        words = '{32'h00000073};
        run_load("restart_l1", 16'd1, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int len;
            do_restart();
            len = $urandom_range(1, MAXW);
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(32'($urandom));
            run_load("random", 16'(len), bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
